// File: rtl/mem_access_if.sv
// Data-memory port between the load/store unit (master) and the memory (slave).
// One outstanding request; ack completes it, with read data valid in the ack cycle.
interface mem_access_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    output mem_be_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    input  mem_be_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_access.sv
// Load/store request unit: aligns stores into byte lanes, issues word reads and
// returns them shifted by the byte offset; stalls upstream while a request is outstanding.
module mem_access #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid_i,
  input  logic [31:0]  addr_i,
  input  logic [31:0]  store_data_i,
  input  logic [1:0]   store_code_i,
  input  logic [2:0]   load_code_i,
  output logic         hold_o,
  output logic [31:0]  load_data_o,
  output logic         load_valid_o,
  output logic         misalign_o,
  output logic         timeout_o,
  mem_access_if.master mem
);

  // Access-code encodings shared with the decode stage; zero means "no access".
  localparam logic [1:0] SCodeNone = 2'd0;
  localparam logic [1:0] SCodeSb   = 2'd1;
  localparam logic [1:0] SCodeSh   = 2'd2;
  localparam logic [2:0] LCodeNone = 3'd0;
  localparam logic [2:0] LCodeLb   = 3'd1;
  localparam logic [2:0] LCodeLh   = 3'd2;
  localparam logic [2:0] LCodeLbu  = 3'd4;
  localparam logic [2:0] LCodeLhu  = 3'd5;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       off_q;
  logic             is_load_q;

  logic        is_store;
  logic        op_valid;
  logic        misaligned;
  logic [1:0]  off;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  always_comb begin
    off        = addr_i[1:0];
    is_store   = (store_code_i != SCodeNone);
    op_valid   = req_valid_i && (is_store || (load_code_i != LCodeNone));
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = store_data_i;
    // A store code takes precedence over any simultaneous load code.
    if (is_store) begin
      case (store_code_i)
        SCodeSb: begin
          be_d    = 4'b0001 << off;
          wdata_d = {4{store_data_i[7:0]}};
        end
        SCodeSh: begin
          misaligned = addr_i[0];
          be_d       = 4'b0011 << off;
          wdata_d    = {2{store_data_i[15:0]}};
        end
        default: misaligned = |off;
      endcase
    end else begin
      case (load_code_i)
        LCodeLb, LCodeLbu: misaligned = 1'b0;
        LCodeLh, LCodeLhu: misaligned = addr_i[0];
        default:           misaligned = |off;
      endcase
    end
    hold_o = (state_q == StWait) || ((state_q == StIdle) && op_valid && !misaligned);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      off_q           <= 2'b00;
      is_load_q       <= 1'b0;
      load_data_o     <= '0;
      load_valid_o    <= 1'b0;
      misalign_o      <= 1'b0;
      timeout_o       <= 1'b0;
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_wdata_o <= '0;
      mem.mem_be_o    <= '0;
    end else begin
      load_valid_o <= 1'b0;
      misalign_o   <= 1'b0;
      timeout_o    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (op_valid) begin
            if (misaligned) begin
              misalign_o <= 1'b1;
            end else begin
              state_q         <= StWait;
              cnt_q           <= '0;
              off_q           <= off;
              is_load_q       <= !is_store;
              mem.mem_req_o   <= 1'b1;
              mem.mem_we_o    <= is_store;
              mem.mem_addr_o  <= {addr_i[31:2], 2'b00};
              mem.mem_wdata_o <= wdata_d;
              mem.mem_be_o    <= be_d;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          // Ack is checked first so an ack on the last allowed cycle still completes.
          if (mem.mem_ack_i) begin
            state_q       <= StDone;
            mem.mem_req_o <= 1'b0;
            if (is_load_q) begin
              load_data_o  <= mem.mem_rdata_i >> {off_q, 3'b000};
              load_valid_o <= 1'b1;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q       <= StDone;
            mem.mem_req_o <= 1'b0;
            timeout_o     <= 1'b1;
            if (is_load_q) begin
              load_data_o  <= '0;
              load_valid_o <= 1'b1;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected memory requests and
// responses; a memory model and a response monitor pop and compare them.
module tb_mem_access;

  localparam logic [1:0] SB = 2'd1, SH = 2'd2, SW = 2'd3;
  localparam logic [2:0] LB = 3'd1, LH = 3'd2, LW = 3'd3, LBU = 3'd4, LHU = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] store_data_i = '0;
  logic [1:0]  store_code_i = '0;
  logic [2:0]  load_code_i = '0;
  logic        hold_o;
  logic [31:0] load_data_o;
  logic        load_valid_o;
  logic        misalign_o;
  logic        timeout_o;

  mem_access_if mem_bus ();

  mem_access #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .store_code_i (store_code_i),
    .load_code_i  (load_code_i),
    .hold_o       (hold_o),
    .load_data_o  (load_data_o),
    .load_valid_o (load_valid_o),
    .misalign_o   (misalign_o),
    .timeout_o    (timeout_o),
    .mem          (mem_bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lv;
    logic        mis;
    logic        to;
    logic [31:0] data;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  rsp_t rsp_q[$];
  req_t req_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          ack_at = -1;
  logic [31:0] rd_word = '0;
  logic        stray = 1'b0;
  int          wait_cnt = 0;
  int          req_cycles = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Memory model: acks in WAIT cycle ack_at, checks the request fields every cycle.
  initial begin : memory_model
    req_t cur;
    logic have_cur;
    logic ack;
    have_cur = 1'b0;
    cur = '0;
    mem_bus.mem_ack_i   = 1'b0;
    mem_bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      if (mem_bus.mem_req_o === 1'b1) begin
        wait_cnt++;
        if (wait_cnt == 1) begin
          if (req_q.size() == 0) begin
            n_checks++;
            n_errors++;
            have_cur = 1'b0;
            $display("FAIL unexpected_req got addr=%h want no request", mem_bus.mem_addr_o);
          end else begin
            cur = req_q.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur) begin
          n_checks++;
          if (mem_bus.mem_we_o !== cur.we || mem_bus.mem_addr_o !== cur.addr ||
              mem_bus.mem_be_o !== cur.be || (cur.we && mem_bus.mem_wdata_o !== cur.wdata)) begin
            n_errors++;
            $display("FAIL req_fields wait=%0d got we=%b addr=%h wdata=%h be=%b want we=%b addr=%h wdata=%h be=%b",
                     wait_cnt, mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_wdata_o,
                     mem_bus.mem_be_o, cur.we, cur.addr, cur.wdata, cur.be);
          end
        end
        ack = (wait_cnt == ack_at);
      end else begin
        if (wait_cnt != 0) req_cycles = wait_cnt;
        wait_cnt = 0;
        have_cur = 1'b0;
      end
      mem_bus.mem_ack_i   = ack | stray;
      mem_bus.mem_rdata_i = rd_word;
    end
  end

  // Response monitor: any output pulse must match the next expected response.
  initial begin : rsp_monitor
    rsp_t exp;
    forever begin
      @(negedge clk);
      if (!rst && (load_valid_o || misalign_o || timeout_o)) begin
        n_checks++;
        if (rsp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_rsp got lv=%b mis=%b to=%b data=%h want none",
                   load_valid_o, misalign_o, timeout_o, load_data_o);
        end else begin
          exp = rsp_q.pop_front();
          if (exp.lv !== load_valid_o || exp.mis !== misalign_o || exp.to !== timeout_o ||
              (exp.lv && exp.data !== load_data_o)) begin
            n_errors++;
            $display("FAIL rsp got lv=%b mis=%b to=%b data=%h want lv=%b mis=%b to=%b data=%h",
                     load_valid_o, misalign_o, timeout_o, load_data_o,
                     exp.lv, exp.mis, exp.to, exp.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // Presents one op at posedge+1, holds it while hold_o is high, returns in the
  // following IDLE cycle with inputs cleared. holds = cycles with hold_o high.
  task automatic run_op(input logic [1:0] sc, input logic [2:0] lc, input logic [31:0] a,
                        input logic [31:0] d, input int ack, input logic [31:0] rd,
                        output int holds);
    ack_at       = ack;
    rd_word      = rd;
    req_valid_i  = 1'b1;
    store_code_i = sc;
    load_code_i  = lc;
    addr_i       = a;
    store_data_i = d;
    holds        = 0;
    @(negedge clk);
    while (hold_o && holds < 40) begin
      holds++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    if (hold_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL hold_bound got=stuck want=release");
    end
    @(posedge clk); #1;
    req_valid_i  = 1'b0;
    store_code_i = '0;
    load_code_i  = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_req"},   {31'd0, mem_bus.mem_req_o}, 32'd0);
    check({tag, "_mem_we"},    {31'd0, mem_bus.mem_we_o}, 32'd0);
    check({tag, "_mem_addr"},  mem_bus.mem_addr_o, 32'd0);
    check({tag, "_mem_wdata"}, mem_bus.mem_wdata_o, 32'd0);
    check({tag, "_mem_be"},    {28'd0, mem_bus.mem_be_o}, 32'd0);
    check({tag, "_load_data"}, load_data_o, 32'd0);
    check({tag, "_load_valid"}, {31'd0, load_valid_o}, 32'd0);
    check({tag, "_misalign"},  {31'd0, misalign_o}, 32'd0);
    check({tag, "_timeout"},   {31'd0, timeout_o}, 32'd0);
    check({tag, "_hold"},      {31'd0, hold_o}, 32'd0);
  endtask

  initial begin : stimulus
    int h;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;

    // SB to byte lane 3, immediate ack.
    req_q.push_back('{we: 1'b1, addr: 32'h1000, wdata: 32'hA5A5A5A5, be: 4'b1000});
    run_op(SB, '0, 32'h1003, 32'h000000A5, 1, 32'h0, h);
    check("sb_hold_cycles", h, 2);

    // LH upper half, ack in third WAIT cycle.
    req_q.push_back('{we: 1'b0, addr: 32'h2000, wdata: 32'h0, be: 4'b1111});
    rsp_q.push_back('{lv: 1'b1, mis: 1'b0, to: 1'b0, data: 32'h00008001});
    run_op('0, LH, 32'h2002, 32'h0, 3, 32'h80011234, h);
    check("lh_hold_cycles", h, 4);
    check("lh_req_cycles", req_cycles, 3);

    // Misaligned SW, then a normal LW right behind it.
    rsp_q.push_back('{lv: 1'b0, mis: 1'b1, to: 1'b0, data: 32'h0});
    run_op(SW, '0, 32'h3001, 32'hDEAD0000, -1, 32'h0, h);
    check("sw_mis_hold_cycles", h, 0);
    req_q.push_back('{we: 1'b0, addr: 32'h3004, wdata: 32'h0, be: 4'b1111});
    rsp_q.push_back('{lv: 1'b1, mis: 1'b0, to: 1'b0, data: 32'h11223344});
    run_op('0, LW, 32'h3004, 32'h0, 2, 32'h11223344, h);
    check("lw_hold_cycles", h, 3);

    // LW against a dead memory: times out after 16 WAIT cycles.
    req_q.push_back('{we: 1'b0, addr: 32'h6000, wdata: 32'h0, be: 4'b1111});
    rsp_q.push_back('{lv: 1'b1, mis: 1'b0, to: 1'b1, data: 32'h0});
    run_op('0, LW, 32'h6000, 32'h0, -1, 32'hFFFFFFFF, h);
    check("to_hold_cycles", h, 17);
    check("to_req_cycles", req_cycles, 16);

    // Ack on the final allowed cycle completes normally.
    req_q.push_back('{we: 1'b0, addr: 32'h7008, wdata: 32'h0, be: 4'b1111});
    rsp_q.push_back('{lv: 1'b1, mis: 1'b0, to: 1'b0, data: 32'hDEADBEEF});
    run_op('0, LW, 32'h7008, 32'h0, 16, 32'hDEADBEEF, h);
    check("late_ack_hold_cycles", h, 17);
    check("late_ack_req_cycles", req_cycles, 16);

    // Store and load codes together: store wins, no load response.
    req_q.push_back('{we: 1'b1, addr: 32'h8000, wdata: 32'h56785678, be: 4'b1100});
    run_op(SH, LW, 32'h8002, 32'h12345678, 1, 32'h0, h);
    check("sh_lw_hold_cycles", h, 2);

    // LB from byte lane 3.
    req_q.push_back('{we: 1'b0, addr: 32'h9000, wdata: 32'h0, be: 4'b1111});
    rsp_q.push_back('{lv: 1'b1, mis: 1'b0, to: 1'b0, data: 32'h00000080});
    run_op('0, LB, 32'h9003, 32'h0, 2, 32'h80FF0011, h);

    // Misaligned LHU.
    rsp_q.push_back('{lv: 1'b0, mis: 1'b1, to: 1'b0, data: 32'h0});
    run_op('0, LHU, 32'h9001, 32'h0, -1, 32'h0, h);
    check("lhu_mis_hold_cycles", h, 0);

    // Reset in the middle of an SH wait.
    req_q.push_back('{we: 1'b1, addr: 32'h4000, wdata: 32'hBEEFBEEF, be: 4'b1100});
    ack_at       = -1;
    req_valid_i  = 1'b1;
    store_code_i = SH;
    addr_i       = 32'h4002;
    store_data_i = 32'h0000BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst          = 1'b1;
    req_valid_i  = 1'b0;
    store_code_i = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");

    // Stray acks while idle must do nothing.
    @(posedge clk); #1;
    stray = 1'b1;
    repeat (3) @(posedge clk);
    #1 stray = 1'b0;
    @(negedge clk);
    check("stray_mem_req", {31'd0, mem_bus.mem_req_o}, 32'd0);
    check("stray_hold", {31'd0, hold_o}, 32'd0);
    @(posedge clk); #1;

    req_q.push_back('{we: 1'b0, addr: 32'h5000, wdata: 32'h0, be: 4'b1111});
    rsp_q.push_back('{lv: 1'b1, mis: 1'b0, to: 1'b0, data: 32'h00CAFEBA});
    run_op('0, LBU, 32'h5001, 32'h0, 1, 32'hCAFEBABE, h);
    check("lbu_hold_cycles", h, 2);

    repeat (4) @(posedge clk);
    #1;
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Load/store request unit between the EX/MEM pipeline register and the data memory port. It is the memory-facing counterpart to the writeback stage:
- Stores: aligns data, generates byte strobes and writes memory.
- Loads: issues a word read and returns the word right-shifted by the byte offset. The writeback stage then sign- or zero-extends it.

It stalls the pipeline through a one-outstanding-request handshake, flags misaligned accesses and times out a dead memory.

## Interface
- TIMEOUT, 16: maximum cycles in WAIT without mem_ack_i before the access is abandoned (2..255)
- CNT_W, 8: width of the wait counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  MEM-stage instruction present
- addr_i  in  32  byte address from ALU
- store_data_i  in  32  rs2 value, right-aligned
- store_code_i  in  `BUS_S_CODE  none / `INSTR_SB / `INSTR_SH / `INSTR_SW
- load_code_i  in  `BUS_L_CODE  none / `INSTR_LB / LH / LW / LBU / LHU (define.v encodings)
- hold_o  out  1  stall upstream stages (combinational)
- load_data_o  out  32  read word shifted right by 8*addr[1:0], registered
- load_valid_o  out  1  one-cycle pulse, load_data_o valid
- misalign_o  out  1  one-cycle pulse, misaligned access dropped
- timeout_o  out  1  one-cycle pulse, access abandoned
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  word address {addr[31:2],2'b00}
- mem_wdata_o  out  32  lane-aligned write data
- mem_be_o  out  4  byte enables
- mem_ack_i  in  1  memory accepted/completed; rdata valid same cycle for reads
- mem_rdata_i  in  32  read word

## Operation
- **States:** IDLE, WAIT, DONE. Reset to IDLE.
- **Op valid:** an op is valid when req_valid_i=1 and (store_code_i≠none or load_code_i≠none). If both codes are non-none, the store wins and the load is ignored.
- **Misalign rules:**
  - H/HU misaligned if addr_i[0]=1.
  - W misaligned if addr_i[1:0]≠0.
  - B never misaligned.
- **IDLE, valid aligned op:** capture the request registers, go to WAIT, hold_o=1 this cycle.
- **IDLE, valid misaligned op:** no memory request, hold_o=0, misalign_o=1 next cycle, stay IDLE.
- **Write lanes (off = addr_i[1:0]):**
  - SB: be = 4'b0001<<off, wdata = {4{d[7:0]}}.
  - SH: be = 4'b0011<<off, wdata = {2{d[15:0]}}.
  - SW: be = 4'b1111, wdata = d.
  - Loads: be = 4'b1111, we = 0.
- **WAIT:**
  - mem_req_o=1, and addr/we/wdata/be are stable until and including the ack cycle. hold_o=1.
  - The counter increments each WAIT cycle.
  - On mem_ack_i, go to DONE. For a load, load_data_o ← mem_rdata_i >> (8*off).
  - If no ack and count = TIMEOUT-1, go to DONE with timeout_o=1 next cycle. load_data_o ← 0 for a load.
  - An ack on the final cycle wins over timeout.
- **DONE:**
  - mem_req_o=0 and hold_o=0.
  - load_valid_o=1 only for a load (including a timed-out load).
  - req_valid_i is ignored, because it still shows the just-completed op.
  - Always go to IDLE next cycle.
- **Stray ack:** mem_ack_i in IDLE or DONE is ignored.
- **Reset mid-operation:** at the next edge go to IDLE. All outputs drop to reset values and the counter clears; the outstanding access is forgotten.

## Timing
- **Reset values:**
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0.
  - load_data_o=0, load_valid_o=0, misalign_o=0, timeout_o=0.
  - hold_o=0 in IDLE with no request.
- **Cycle sequence:**
  - Cycle 0: op accepted, hold_o=1.
  - Cycle 1: mem_req_o=1 (registered).
  - Ack in cycle k≥1.
  - Cycle k+1: DONE, hold_o=0, load_valid_o pulse.
  - Cycle k+2: IDLE, next op acceptable.
- **Latency:** minimum latency (ack in cycle 1) is 3 cycles accept-to-accept. Maximum WAIT is TIMEOUT cycles.
- **Misalign:** misalign_o asserts the cycle after the offending op is presented and lasts exactly 1 cycle.
- **Outstanding:** at most one outstanding request, with no pipelining.

## Test plan
- SB addr=0x1003, data=0xA5, ack in cycle 1 -> mem_addr_o=0x1000, be=4'b1000, wdata=0xA5A5A5A5, we=1; hold_o high for cycles 0–1, low at cycle 2; no load_valid_o.
- LH addr=0x2002, rdata=0x8001_1234, ack after 3 WAIT cycles -> be=4'b1111, we=0; load_data_o=0x0000_8001 with load_valid_o pulse in the cycle after ack; mem_req_o stable throughout WAIT.
- SW addr=0x3001 -> mem_req_o never rises, hold_o=0, misalign_o one-cycle pulse next cycle; then LW addr=0x3004 proceeds normally.
- LW with no ack, TIMEOUT=16 -> mem_req_o high exactly 16 cycles, timeout_o pulse, load_valid_o pulse with load_data_o=0, back to IDLE.
- Ack in the 16th WAIT cycle -> normal completion, no timeout_o.
- rst asserted during WAIT of an SH -> next cycle mem_req_o=0, IDLE, all outputs at reset values; stray mem_ack_i afterwards has no effect; new LBU addr=0x5001 completes with load_data_o = rdata>>8.
